// File: rtl/oai33_bist_pkg.sv
// Shared types, constants and golden model for the OAI33 exhaustive BIST.
package oai33_bist_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      CHECK   = 2'd2,
      DONE_ST = 2'd3
   } state_t;

   localparam int VEC_W = 6;
   localparam logic [VEC_W-1:0] LAST_VEC = 6'd63;

   // Bit positions of the cell pins inside the packed {B3,B2,B1,A3,A2,A1} vector
   localparam int A1_IDX = 0;
   localparam int A2_IDX = 1;
   localparam int A3_IDX = 2;
   localparam int B1_IDX = 3;
   localparam int B2_IDX = 4;
   localparam int B3_IDX = 5;

   // Expected ZN for one stimulus vector
   function automatic logic oai33_golden(input logic [VEC_W-1:0] vec);
      return ~((vec[A1_IDX] | vec[A2_IDX] | vec[A3_IDX]) &
               (vec[B1_IDX] | vec[B2_IDX] | vec[B3_IDX]));
   endfunction

endpackage

// File: rtl/oai33_bist_cnt.sv
// Settle counter and stimulus vector counter; the vector drives the cell pins from flops.
module oai33_bist_cnt
   import oai33_bist_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             settle_en,
   input  logic             adv,
   output logic [VEC_W-1:0] vec,
   output logic             settle_done,
   output logic             last
);

   logic [3:0] cnt;

   // Clear on run start, step the vector after each check, count settle cycles otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         vec <= '0;
      end else if (clr) begin
         cnt <= '0;
         vec <= '0;
      end else if (adv) begin
         cnt <= '0;
         vec <= vec + 1'b1;
      end else if (settle_en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign settle_done = (cnt == 4'(SETTLE_CYCLES - 1));
   assign last        = (vec == LAST_VEC);

endmodule

// File: rtl/oai33_bist_seq.sv
// Exhaustive BIST sequencer for the OAI33 cell: sweeps 64 vectors, checks ZN, records results.
module oai33_bist_seq
   import oai33_bist_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int ERR_W         = 7
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             ZN_IN,
   output logic             A1,
   output logic             A2,
   output logic             A3,
   output logic             B1,
   output logic             B2,
   output logic             B3,
   output logic             BUSY,
   output logic             DONE,
   output logic             PASS,
   output logic [ERR_W-1:0] ERR_CNT,
   output logic [VEC_W-1:0] FAIL_VEC,
   output logic             FAIL_VALID
);

   state_t           state, nxt;
   logic             clr, settle_en, adv, check;
   logic             settle_done, last, mismatch;
   logic [VEC_W-1:0] vec;

   oai33_bist_cnt #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_cnt (
      .clk         (CLK),
      .rst         (RST),
      .clr         (clr),
      .settle_en   (settle_en),
      .adv         (adv),
      .vec         (vec),
      .settle_done (settle_done),
      .last        (last)
   );

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= nxt;
   end

   // Next-state and counter control; START only matters when not running
   always_comb begin
      nxt       = state;
      clr       = 1'b0;
      settle_en = 1'b0;
      adv       = 1'b0;
      check     = 1'b0;
      case (state)
         IDLE, DONE_ST: begin
            if (START) begin
               clr = 1'b1;
               nxt = SETTLE;
            end
         end
         SETTLE: begin
            settle_en = 1'b1;
            if (settle_done) nxt = CHECK;
         end
         CHECK: begin
            check = 1'b1;
            if (last) begin
               nxt = DONE_ST;
            end else begin
               adv = 1'b1;
               nxt = SETTLE;
            end
         end
         default: nxt = IDLE;
      endcase
   end

   assign mismatch = check & (ZN_IN != oai33_golden(vec));

   // Result capture: saturating error count and first failing vector
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ERR_CNT    <= '0;
         FAIL_VEC   <= '0;
         FAIL_VALID <= 1'b0;
      end else if (clr) begin
         ERR_CNT    <= '0;
         FAIL_VEC   <= '0;
         FAIL_VALID <= 1'b0;
      end else if (mismatch) begin
         if (ERR_CNT != '1) ERR_CNT <= ERR_CNT + 1'b1;
         if (!FAIL_VALID) begin
            FAIL_VEC   <= vec;
            FAIL_VALID <= 1'b1;
         end
      end
   end

   assign A1   = vec[A1_IDX];
   assign A2   = vec[A2_IDX];
   assign A3   = vec[A3_IDX];
   assign B1   = vec[B1_IDX];
   assign B2   = vec[B2_IDX];
   assign B3   = vec[B3_IDX];
   assign BUSY = (state == SETTLE) || (state == CHECK);
   assign DONE = (state == DONE_ST);
   assign PASS = DONE && (ERR_CNT == '0);

endmodule

// File: tb/tb_oai33_bist_seq.sv
// Directed bench for oai33_bist_seq with a switchable cell model on ZN_IN.
module tb_oai33_bist_seq;

   localparam int ERR_W = 7;
   localparam int RUN   = 64 * 3;  // edges per run with SETTLE_CYCLES=2

   logic             CLK = 1'b0;
   logic             RST = 1'b1;
   logic             START = 1'b0;
   logic             ZN_IN;
   logic             A1, A2, A3, B1, B2, B3;
   logic             BUSY, DONE, PASS, FAIL_VALID;
   logic [ERR_W-1:0] ERR_CNT;
   logic [5:0]       FAIL_VEC;
   logic [5:0]       vec_o;
   int               mode = 0;  // 0: good cell, 1: stuck-at-1, 2: stuck-at-0
   int               n_chk = 0;
   int               n_fail = 0;

   oai33_bist_seq #(.SETTLE_CYCLES(2), .ERR_W(ERR_W)) dut (
      .CLK(CLK), .RST(RST), .START(START), .ZN_IN(ZN_IN),
      .A1(A1), .A2(A2), .A3(A3), .B1(B1), .B2(B2), .B3(B3),
      .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .ERR_CNT(ERR_CNT),
      .FAIL_VEC(FAIL_VEC), .FAIL_VALID(FAIL_VALID)
   );

   always #5 CLK = ~CLK;

   assign vec_o = {B3, B2, B1, A3, A2, A1};

   always_comb begin
      ZN_IN = 1'b0;
      case (mode)
         0:       ZN_IN = ~((A1 | A2 | A3) & (B1 | B2 | B3));
         1:       ZN_IN = 1'b1;
         default: ZN_IN = 1'b0;
      endcase
   end

   task automatic edges(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // START high across exactly one edge (edge 0); returns 1 unit after it
   task automatic start_run();
      START = 1'b1;
      edges(1);
      START = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      #2;
      n_chk++; if (vec_o !== 6'h00) begin n_fail++; $display("FAIL reset_vec: got %h exp 00", vec_o); end
      n_chk++; if ({BUSY, DONE, PASS, FAIL_VALID} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b exp 0000", {BUSY, DONE, PASS, FAIL_VALID}); end
      n_chk++; if (ERR_CNT !== 7'd0 || FAIL_VEC !== 6'd0) begin n_fail++; $display("FAIL reset_results: got err=%0d fv=%b exp 0/0", ERR_CNT, FAIL_VEC); end
      @(negedge CLK);
      RST = 1'b0;
      edges(2);
      n_chk++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin n_fail++; $display("FAIL idle_hold: got busy=%b done=%b exp 0/0", BUSY, DONE); end
   endtask

   task automatic test_good_cell();
      mode = 0;
      start_run();
      n_chk++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL good_busy: got %b exp 1", BUSY); end
      edges(RUN - 1);
      n_chk++; if (DONE !== 1'b0 || BUSY !== 1'b1) begin n_fail++; $display("FAIL good_early: got done=%b busy=%b exp 0/1", DONE, BUSY); end
      edges(1);
      n_chk++; if (DONE !== 1'b1 || BUSY !== 1'b0) begin n_fail++; $display("FAIL good_done: got done=%b busy=%b exp 1/0", DONE, BUSY); end
      n_chk++; if (PASS !== 1'b1 || ERR_CNT !== 7'd0 || FAIL_VALID !== 1'b0) begin n_fail++; $display("FAIL good_result: got pass=%b err=%0d fvld=%b exp 1/0/0", PASS, ERR_CNT, FAIL_VALID); end
      n_chk++; if (vec_o !== 6'h3F) begin n_fail++; $display("FAIL good_lastvec: got %h exp 3f", vec_o); end
      edges(3);
      n_chk++; if (DONE !== 1'b1 || vec_o !== 6'h3F || PASS !== 1'b1) begin n_fail++; $display("FAIL good_hold: got done=%b vec=%h pass=%b exp 1/3f/1", DONE, vec_o, PASS); end
   endtask

   task automatic test_stuck1();
      mode = 1;
      start_run();
      edges(RUN);
      n_chk++; if (ERR_CNT !== 7'd49) begin n_fail++; $display("FAIL s1_errcnt: got %0d exp 49", ERR_CNT); end
      n_chk++; if (FAIL_VEC !== 6'b001001 || FAIL_VALID !== 1'b1) begin n_fail++; $display("FAIL s1_failvec: got %b vld=%b exp 001001/1", FAIL_VEC, FAIL_VALID); end
      n_chk++; if (PASS !== 1'b0 || DONE !== 1'b1) begin n_fail++; $display("FAIL s1_pass: got pass=%b done=%b exp 0/1", PASS, DONE); end
   endtask

   task automatic test_stuck0();
      mode = 2;
      start_run();
      n_chk++; if (FAIL_VALID !== 1'b0 || ERR_CNT !== 7'd0) begin n_fail++; $display("FAIL s0_clear: got vld=%b err=%0d exp 0/0", FAIL_VALID, ERR_CNT); end
      edges(RUN);
      n_chk++; if (ERR_CNT !== 7'd15) begin n_fail++; $display("FAIL s0_errcnt: got %0d exp 15", ERR_CNT); end
      n_chk++; if (FAIL_VEC !== 6'b000000 || FAIL_VALID !== 1'b1 || PASS !== 1'b0) begin n_fail++; $display("FAIL s0_result: got fv=%b vld=%b pass=%b exp 000000/1/0", FAIL_VEC, FAIL_VALID, PASS); end
   endtask

   task automatic test_sweep();
      logic [5:0] exp_v;
      mode = 0;
      start_run();
      for (int k = 0; k < RUN; k++) begin
         exp_v = 6'(k / 3);
         n_chk++; if (vec_o !== exp_v) begin n_fail++; $display("FAIL sweep_k%0d: got %h exp %h", k, vec_o, exp_v); end
         edges(1);
      end
      n_chk++; if (vec_o !== 6'h3F || DONE !== 1'b1) begin n_fail++; $display("FAIL sweep_end: got vec=%h done=%b exp 3f/1", vec_o, DONE); end
   endtask

   task automatic test_restart_ignored();
      mode = 1;
      start_run();
      edges(49);
      START = 1'b1;
      edges(1);  // edge 50
      START = 1'b0;
      n_chk++; if (BUSY !== 1'b1 || vec_o !== 6'd16) begin n_fail++; $display("FAIL rs_busy: got busy=%b vec=%h exp 1/10", BUSY, vec_o); end
      edges(RUN - 51);
      n_chk++; if (DONE !== 1'b0) begin n_fail++; $display("FAIL rs_early: got done=%b exp 0", DONE); end
      edges(1);
      n_chk++; if (DONE !== 1'b1 || ERR_CNT !== 7'd49 || FAIL_VEC !== 6'b001001) begin n_fail++; $display("FAIL rs_result: got done=%b err=%0d fv=%b exp 1/49/001001", DONE, ERR_CNT, FAIL_VEC); end
   endtask

   task automatic test_reset_midrun();
      mode = 1;
      start_run();
      edges(99);
      @(posedge CLK);  // edge 100
      #2;
      RST = 1'b1;
      #1;
      n_chk++; if (BUSY !== 1'b0 || vec_o !== 6'h00 || ERR_CNT !== 7'd0) begin n_fail++; $display("FAIL mr_async: got busy=%b vec=%h err=%0d exp 0/00/0", BUSY, vec_o, ERR_CNT); end
      n_chk++; if (FAIL_VALID !== 1'b0 || FAIL_VEC !== 6'd0 || DONE !== 1'b0) begin n_fail++; $display("FAIL mr_results: got vld=%b fv=%b done=%b exp 0/0/0", FAIL_VALID, FAIL_VEC, DONE); end
      @(negedge CLK);
      RST = 1'b0;
      start_run();
      edges(RUN);
      n_chk++; if (DONE !== 1'b1 || ERR_CNT !== 7'd49 || FAIL_VEC !== 6'b001001) begin n_fail++; $display("FAIL mr_rerun: got done=%b err=%0d fv=%b exp 1/49/001001", DONE, ERR_CNT, FAIL_VEC); end
   endtask

   task automatic test_back_to_back();
      mode = 0;
      START = 1'b1;
      edges(1);  // edge 0
      edges(RUN);
      n_chk++; if (DONE !== 1'b1 || PASS !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got done=%b pass=%b exp 1/1", DONE, PASS); end
      edges(1);
      n_chk++; if (DONE !== 1'b0 || BUSY !== 1'b1 || vec_o !== 6'h00) begin n_fail++; $display("FAIL b2b_restart: got done=%b busy=%b vec=%h exp 0/1/00", DONE, BUSY, vec_o); end
      START = 1'b0;
      edges(RUN);
      n_chk++; if (DONE !== 1'b1 || PASS !== 1'b1) begin n_fail++; $display("FAIL b2b_second: got done=%b pass=%b exp 1/1", DONE, PASS); end
   endtask

   initial begin
      test_reset();
      test_good_cell();
      test_stuck1();
      test_stuck0();
      test_sweep();
      test_restart_ignored();
      test_reset_midrun();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
